// File: rtl/acc_group.sv
// acc_group: sums num_reads_per_iter product groups lane-by-lane per iteration
// and emits one accumulated group downstream per iteration, for num_iters iterations.
module acc_group #(
    parameter int unsigned GROUP_SIZE             = 8,
    parameter int unsigned IN_WIDTH               = 16,
    parameter int unsigned ACC_WIDTH              = 32,
    parameter int unsigned LOG_MAX_ITERS          = 16,
    parameter int unsigned LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [GROUP_SIZE*IN_WIDTH-1:0]    data_in,
    input  logic                              valid_in,
    output logic                              avail_out,
    output logic [GROUP_SIZE*ACC_WIDTH-1:0]   data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              busy
);

    localparam int unsigned DataWidth = GROUP_SIZE * IN_WIDTH;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    // 4-slot input FIFO
    logic [DataWidth-1:0] fifo_mem_q [4];
    logic [1:0]           wr_ptr_q, rd_ptr_q;
    logic [2:0]           count_q, count_d;
    logic                 fifo_empty, fifo_full, fifo_almost_full;
    logic                 wr_en;
    logic [DataWidth-1:0] fifo_head;

    state_e state_q, state_d;

    logic [LOG_MAX_ITERS-1:0]                iters_q;
    logic [LOG_MAX_READS_PER_ITER-1:0]       reads_q, reads_init_q;
    logic                                    first_q;
    logic                                    pend_q;
    logic [GROUP_SIZE-1:0][ACC_WIDTH-1:0]    acc_q, sum_d, out_q;

    logic cfg_ok, last_read, last_iter, cons;

    assign fifo_empty       = (count_q == 3'd0);
    assign fifo_full        = (count_q == 3'd4);
    assign fifo_almost_full = (count_q == 3'd3);
    assign fifo_head        = fifo_mem_q[rd_ptr_q];
    assign wr_en            = valid_in & ~fifo_full;

    // A configure with a zero count is ignored entirely
    assign cfg_ok    = configure & (num_iters != '0) & (num_reads_per_iter != '0);
    assign last_read = (reads_q == LOG_MAX_READS_PER_ITER'(1));
    assign last_iter = (iters_q == LOG_MAX_ITERS'(1));
    // The final read of an iteration waits until the previous group has left
    assign cons      = (state_q == StRun) & ~fifo_empty & ~(last_read & pend_q) & ~cfg_ok;

    assign avail_out = ~fifo_almost_full & ~fifo_full;
    assign valid_out = pend_q & avail_in;
    assign data_out  = out_q;
    assign busy      = (state_q == StRun) | pend_q;

    // FIFO occupancy next-state
    always_comb begin
        count_d = count_q + 3'(wr_en) - 3'(cons);
    end

    // FIFO storage and pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                fifo_mem_q[wr_ptr_q] <= data_in;
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (cons) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            count_q <= count_d;
        end
    end

    // Per-lane zero-extended sum of the FIFO head into the accumulators
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            sum_d[i] = first_q ? ACC_WIDTH'(fifo_head[i*IN_WIDTH +: IN_WIDTH])
                               : acc_q[i] + ACC_WIDTH'(fifo_head[i*IN_WIDTH +: IN_WIDTH]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start on a valid configure, stop after the last read of the last iteration
    always_comb begin
        state_d = state_q;
        if (cfg_ok) begin
            state_d = StRun;
        end else if (cons && last_read && last_iter) begin
            state_d = StIdle;
        end
    end

    // Counters, accumulators and the pending output group
    always_ff @(posedge clk) begin
        if (!rst) begin
            iters_q      <= '0;
            reads_q      <= '0;
            reads_init_q <= '0;
            first_q      <= 1'b1;
            acc_q        <= '0;
            out_q        <= '0;
            pend_q       <= 1'b0;
        end else if (cfg_ok) begin
            iters_q      <= num_iters;
            reads_q      <= num_reads_per_iter;
            reads_init_q <= num_reads_per_iter;
            first_q      <= 1'b1;
            acc_q        <= '0;
            pend_q       <= 1'b0;
        end else begin
            if (cons) begin
                acc_q   <= sum_d;
                first_q <= last_read;
                if (last_read) begin
                    out_q   <= sum_d;
                    reads_q <= reads_init_q;
                    iters_q <= iters_q - LOG_MAX_ITERS'(1);
                end else begin
                    reads_q <= reads_q - LOG_MAX_READS_PER_ITER'(1);
                end
            end
            // A new group landing wins over the send of the old one
            if (cons && last_read) begin
                pend_q <= 1'b1;
            end else if (valid_out) begin
                pend_q <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    logic [31:0] cycle_q;

    // Simulation-only cycle count, overflow report and output trace
    always_ff @(posedge clk) begin
        if (!rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (valid_in && fifo_full) begin
                $error("acc_group: write while FIFO full, data dropped");
            end
            if (valid_out) begin
                $info("acc_group: cycle %0d data_out %h", cycle_q, data_out);
            end
        end
    end
`endif

endmodule

// File: tb/tb_acc_group.sv
// Bench for acc_group: two instances (32-bit and 16-bit accumulators) share stimulus;
// a queue model of the FIFO stream produces expected group sums.
module tb_acc_group;

    localparam int unsigned GS = 2;
    localparam int unsigned IW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            configure = 1'b0;
    logic [15:0]     num_iters = '0;
    logic [15:0]     num_reads = '0;
    logic [GS*IW-1:0] data_in = '0;
    logic            valid_in = 1'b0;
    logic            avail_in = 1'b1;

    logic            avail_out_a, valid_out_a, busy_a;
    logic [GS*32-1:0] data_out_a;
    logic            avail_out_b, valid_out_b, busy_b;
    logic [GS*16-1:0] data_out_b;

    acc_group #(.GROUP_SIZE(GS), .IN_WIDTH(IW), .ACC_WIDTH(32)) dut_a (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out_a), .data_out(data_out_a), .valid_out(valid_out_a),
        .avail_in(avail_in), .busy(busy_a)
    );

    acc_group #(.GROUP_SIZE(GS), .IN_WIDTH(IW), .ACC_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
        .num_reads_per_iter(num_reads), .data_in(data_in), .valid_in(valid_in),
        .avail_out(avail_out_b), .data_out(data_out_b), .valid_out(valid_out_b),
        .avail_in(avail_in), .busy(busy_b)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_out_a = 0;
    logic [GS*32-1:0] last_a = '0;
    logic [GS*16-1:0] last_b = '0;

    // Model: groups written into the FIFO, and the groups expected out of each instance
    logic [GS*IW-1:0] stream [$];
    logic [GS*32-1:0] exp_a [$];
    logic [GS*16-1:0] exp_b [$];

    // Compare every emitted group against the model
    always @(negedge clk) begin
        if (rst) begin
            if (valid_out_a) begin
                n_vec++;
                n_out_a++;
                last_a = data_out_a;
                if (exp_a.size() == 0) begin
                    n_err++;
                    $display("FAIL out_a: got %h, required no output", data_out_a);
                end else begin
                    logic [GS*32-1:0] e;
                    e = exp_a.pop_front();
                    if (data_out_a !== e) begin
                        n_err++;
                        $display("FAIL out_a: got %h, required %h", data_out_a, e);
                    end
                end
            end
            if (valid_out_b) begin
                n_vec++;
                last_b = data_out_b;
                if (exp_b.size() == 0) begin
                    n_err++;
                    $display("FAIL out_b: got %h, required no output", data_out_b);
                end else begin
                    logic [GS*16-1:0] e;
                    e = exp_b.pop_front();
                    if (data_out_b !== e) begin
                        n_err++;
                        $display("FAIL out_b: got %h, required %h", data_out_b, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [GS*IW-1:0] grp(input logic [15:0] l1, input logic [15:0] l0);
        return {l1, l0};
    endfunction

    // Write one group, honouring avail_out with a bounded wait
    task automatic push(input logic [GS*IW-1:0] g);
        int t = 0;
        while (!avail_out_a && t < 50) begin
            tick();
            t++;
        end
        if (!avail_out_a) begin
            n_vec++;
            n_err++;
            $display("FAIL push_wait: got avail_out 0, required 1");
        end else begin
            valid_in = 1'b1;
            data_in  = g;
            tick();
            valid_in = 1'b0;
            stream.push_back(g);
        end
    endtask

    task automatic cfg(input int iters, input int reads);
        configure = 1'b1;
        num_iters = 16'(iters);
        num_reads = 16'(reads);
        tick();
        configure = 1'b0;
    endtask

    // Model: each iteration sums the next `reads` groups of the stream per lane
    task automatic expect_iters(input int iters, input int reads);
        for (int it = 0; it < iters; it++) begin
            logic [GS-1:0][31:0] sa;
            logic [GS-1:0][15:0] sb;
            sa = '0;
            sb = '0;
            for (int r = 0; r < reads; r++) begin
                logic [GS*IW-1:0] g;
                g = stream.pop_front();
                for (int l = 0; l < GS; l++) begin
                    sa[l] = sa[l] + 32'(g[l*IW +: IW]);
                    sb[l] = sb[l] + g[l*IW +: IW];
                end
            end
            exp_a.push_back(sa);
            exp_b.push_back(sb);
        end
    endtask

    task automatic wait_outputs(input string name);
        int t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 200) begin
            tick();
            t++;
        end
        n_vec++;
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_err++;
            $display("FAIL %s: got %0d/%0d groups still owed, required 0/0", name,
                     exp_a.size(), exp_b.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        stream.delete();
    endtask

    initial begin
        int outs0;
        int writes;
        avail_in = 1'b1;
        do_reset();

        // Reset state
        check("rst_avail_out", 64'(avail_out_a), 64'd1);
        check("rst_valid_out", 64'(valid_out_a), 64'd0);
        check("rst_busy", 64'(busy_a), 64'd0);
        check("rst_data_out", 64'(data_out_a), 64'd0);
        check("rst_avail_out_b", 64'(avail_out_b), 64'd1);

        // Three-read sum, lane1 carries past 16 bits
        cfg(1, 3);
        check("run_busy", 64'(busy_a), 64'd1);
        push(grp(16'hFFFF, 16'h0010));
        push(grp(16'hFFFF, 16'h0020));
        push(grp(16'hFFFF, 16'h0030));
        expect_iters(1, 3);
        wait_outputs("sum3_done");
        check("sum3_literal_a", 64'(last_a), {32'h0002FFFD, 32'h00000060});
        tick();
        tick();
        check("sum3_busy_after", 64'(busy_a), 64'd0);

        // Backpressure: first group held, next iteration's final read stalls
        do_reset();
        cfg(2, 2);
        avail_in = 1'b0;
        outs0 = n_out_a;
        for (int v = 1; v <= 6; v++) push(grp(16'(v), 16'(v)));
        check("bp_avail_out_low", 64'(avail_out_a), 64'd0);
        for (int c = 0; c < 10; c++) tick();
        check("bp_held_busy", 64'(busy_a), 64'd1);
        check("bp_no_output", 64'(n_out_a - outs0), 64'd0);
        expect_iters(2, 2);
        avail_in = 1'b1;
        wait_outputs("bp_done");
        check("bp_out_count", 64'(n_out_a - outs0), 64'd2);
        check("bp_last_literal", 64'(last_a), {32'd7, 32'd7});
        tick();
        tick();
        check("bp_busy_after", 64'(busy_a), 64'd0);
        check("bp_avail_leftover", 64'(avail_out_a), 64'd1);

        // Unconfigured: FIFO fills to three and avail_out falls
        do_reset();
        writes = 0;
        for (int k = 0; k < 4; k++) begin
            if (avail_out_a) begin
                push(grp(16'(16'h8000 + k), 16'(16'h0100 + k)));
                writes++;
            end
            if (k == 1) check("fill_avail_after2", 64'(avail_out_a), 64'd1);
        end
        check("fill_writes", 64'(writes), 64'd3);
        check("fill_avail_after3", 64'(avail_out_a), 64'd0);
        cfg(1, 3);
        expect_iters(1, 3);
        wait_outputs("fill_done");
        check("fill_literal_a", 64'(last_a), {32'h00018003, 32'h00000303});

        // Wrap: 16-bit accumulator wraps, 32-bit one does not
        do_reset();
        cfg(1, 2);
        push(grp(16'hFFFF, 16'hFFFF));
        push(grp(16'h0002, 16'h0002));
        expect_iters(1, 2);
        wait_outputs("wrap_done");
        check("wrap_literal_b", 64'(last_b), {16'h0001, 16'h0001});
        check("wrap_literal_a", 64'(last_a), {32'h00010001, 32'h00010001});

        // Reconfigure after two consumes: accumulators restart
        do_reset();
        push(grp(16'h0001, 16'h0011));
        push(grp(16'h0002, 16'h0022));
        push(grp(16'h0004, 16'h0044));
        cfg(2, 4);
        tick();
        tick();
        cfg(1, 2);
        void'(stream.pop_front());
        void'(stream.pop_front());
        push(grp(16'h0008, 16'h0088));
        expect_iters(1, 2);
        wait_outputs("recfg_done");
        check("recfg_literal_a", 64'(last_a), {32'h0000000C, 32'h000000CC});

        // Zero-count configure is ignored; FIFO keeps its data
        do_reset();
        push(grp(16'h0100, 16'h0005));
        push(grp(16'h0200, 16'h0006));
        cfg(0, 3);
        tick();
        tick();
        tick();
        check("zero_cfg_busy", 64'(busy_a), 64'd0);
        check("zero_cfg_no_output", 64'(valid_out_a), 64'd0);
        cfg(1, 2);
        expect_iters(1, 2);
        wait_outputs("zero_cfg_done");
        check("zero_cfg_literal_a", 64'(last_a), {32'h00000300, 32'h0000000B});

        // Reset mid-run
        cfg(1, 3);
        push(grp(16'h1234, 16'h5678));
        rst = 1'b0;
        tick();
        check("midrst_avail_out", 64'(avail_out_a), 64'd1);
        check("midrst_valid_out", 64'(valid_out_a), 64'd0);
        check("midrst_busy", 64'(busy_a), 64'd0);
        check("midrst_data_out", 64'(data_out_a), 64'd0);
        rst = 1'b1;
        stream.delete();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acc_group.md
Name: acc_group

Overview:
- Accumulates the grouped product stream from the multiplier stage (the receiving end of the multiplier's data/valid/avail output interface).
- Each iteration sums num_reads_per_iter input groups lane-by-lane into GROUP_SIZE accumulators and emits one accumulated group downstream.
- After num_iters iterations the block disables itself.
- Sits between the multiplier and the output writer in the conv datapath.

Parameters:
- GROUP_SIZE, 8, lanes per group
- IN_WIDTH, 16, input item width (2x multiplier data width)
- ACC_WIDTH, 32, accumulator/output item width; must be >= IN_WIDTH
- LOG_MAX_ITERS, 16, bits of num_iters
- LOG_MAX_READS_PER_ITER, 16, bits of num_reads_per_iter

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- configure  in  1  CONFIGURE: load counters and start
- num_iters  in  LOG_MAX_ITERS  CONFIGURE: iterations
- num_reads_per_iter  in  LOG_MAX_READS_PER_ITER  CONFIGURE: groups summed per iteration
- data_in  in  GROUP_SIZE*IN_WIDTH  IN: product group, lane i at bits [(i+1)*IN_WIDTH-1 : i*IN_WIDTH]
- valid_in  in  1  IN: write strobe
- avail_out  out  1  IN: block can take data
- data_out  out  GROUP_SIZE*ACC_WIDTH  OUT: accumulated group, same lane packing
- valid_out  out  1  OUT: data_out transferred this cycle
- avail_in  in  1  OUT: downstream accepts this cycle
- busy  out  1  enabled or output pending

Behaviour:
- Reset: avail_out=1, valid_out=0, busy=0, data_out=0. Accumulators, counters and pending flag are cleared; the FIFO is emptied; state is IDLE.
- Input side:
  - Uses the existing 4-slot FIFO block at width GROUP_SIZE*IN_WIDTH.
  - A write occurs every cycle valid_in=1. Sender asserts valid_in only in cycles where avail_out=1.
  - avail_out = ~almost_full & ~full. Deasserts at 3 occupied slots, giving one slot of slack for senders with a registered avail.
  - Data written at edge t is at the FIFO head in cycle t+1.
- States: IDLE, RUN.
  - IDLE -> RUN on configure with num_iters!=0 and num_reads_per_iter!=0.
  - configure with either value 0 is ignored; state is unchanged.
  - RUN -> IDLE on consuming the last read of the last iteration.
- Consume condition: cons = RUN & ~fifo_empty & ~(last_read & pend). Pops the FIFO head.
  - last_read = (reads counter == 1).
  - pend = output register holds an unsent group.
- Accumulate on cons, per lane, zero-extended unsigned:
  - First read of an iteration: acc <= item.
  - Otherwise: acc <= acc + item.
  - Sums wrap modulo 2^ACC_WIDTH. No saturation, no overflow flag.
- Iteration counting:
  - On cons with last_read: out_reg <= acc + item for all lanes (item alone when num_reads_per_iter=1), and pend <= 1.
  - Same cycle: reads counter reloads from its saved copy and the iteration counter decrements.
  - On cons without last_read: the reads counter decrements.
- Output side:
  - valid_out = pend & avail_in (combinational); data_out = out_reg.
  - pend clears on the edge where valid_out=1.
  - pend set and cleared in the same cycle: set wins, out_reg takes the new group.
  - Latency: last-read consume at cycle t -> valid_out earliest at t+1.
- Backpressure: accumulation of the next iteration continues while pend=1. Only its final read stalls until pend clears. Holding avail_in low therefore backs up the FIFO and drops avail_out.
- busy = RUN | pend. The final group may still be pending in IDLE.
- configure in any state (including RUN):
  - Reloads counters, clears accumulators and pend, and sets first-read.
  - Configure takes priority over consume in the same cycle.
  - FIFO contents are retained; the upstream stage is responsible for stream alignment.
- valid_in together with configure: the write is still accepted into the FIFO.
- A write while full is a protocol violation. Data is dropped; simulation prints an error.
- Reset mid-operation: returns to the reset state next edge. Any pending output is lost.
- Simulation-only debug: on each valid_out, print cycle count and data_out.

Test Plan:
- GROUP_SIZE=2, ACC_WIDTH=32, iters=1, reads=3, lane0 0x0010/0x0020/0x0030, lane1 0xFFFF x3, avail_in=1 -> one valid_out, lane0=0x00000060, lane1=0x0002FFFD, then busy=0.
- iters=2, reads=2, inputs 1,2,3,4 (all lanes), avail_in=0 for 10 cycles after first sum -> first output 3 held, 3rd item consumed, 4th stalls. On avail_in=1: outputs 3 then 7 on separate cycles, no loss.
- Unconfigured block, 4 back-to-back writes attempted -> avail_out falls after the 3rd write. After configure (reads=3, iters=1), one output equal to the lane sums.
- ACC_WIDTH=16, reads=2, lane items 0xFFFF and 0x0002 -> output 0x0001 (wrap).
- configure with iters=2, reads=4; after 2 consumes, configure with iters=1, reads=2 -> accumulators restart. Output = sum of the next 2 FIFO items only.
- configure with num_iters=0 -> state stays IDLE, busy=0, FIFO not consumed. Reset asserted mid-RUN -> next cycle avail_out=1, valid_out=0, busy=0.
